// File: rtl/ula_vram_pkg.sv
// Shared definitions for the ULA video RAM fetch sequencer.
// Holds the 8-cycle slot timing constants, the default DRAM
// multiplexed-address width, and the slot-mode encoding.
package ula_vram_pkg;

  localparam int unsigned MA_W_DEFAULT = 7;
  localparam int unsigned SC_W         = 3;

  // Slot cycle landmarks: row strobe starts and data-latch cycles.
  localparam logic [SC_W-1:0] CYC_ROW_B = 3'd0;
  localparam logic [SC_W-1:0] CYC_LAT_B = 3'd3;
  localparam logic [SC_W-1:0] CYC_ROW_A = 3'd4;
  localparam logic [SC_W-1:0] CYC_LAT_A = 3'd7;

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_mode_e;

endpackage

// File: rtl/ula_vram_slot_ctr.sv
// Slot cycle counter and DRAM refresh row counter.
// Ports:
//   clk, n_reset   - pixel clock, async active-low reset
//   rfsh_inc       - advance the refresh row on this edge
//   sc             - current slot cycle (0..7)
//   sc_next_c      - slot cycle after the coming edge
//   slot_start_c   - the coming edge wraps sc 7->0
//   rfsh           - refresh row address
module ula_vram_slot_ctr #(
  parameter int unsigned MA_W = ula_vram_pkg::MA_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          rfsh_inc,
  output logic [ula_vram_pkg::SC_W-1:0] sc,
  output logic [ula_vram_pkg::SC_W-1:0] sc_next_c,
  output logic                          slot_start_c,
  output logic [MA_W-1:0]               rfsh
);
  import ula_vram_pkg::*;

  assign sc_next_c    = sc + SC_W'(1);
  assign slot_start_c = (sc == CYC_LAT_A);

  // Free-running slot counter and wrap-around refresh row counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sc   <= '0;
      rfsh <= '0;
    end else begin
      sc <= sc_next_c;
      if (rfsh_inc) rfsh <= rfsh + MA_W'(1);
    end
  end

endmodule

// File: rtl/ula_vram_fetch.sv
// ULA video RAM fetch sequencer: per 8-cycle slot either fetches a
// bitmap and an attribute byte from DRAM, or does a RAS-only refresh.
// Ports:
//   clk, n_reset            - pixel clock, async active-low reset
//   fetch_en                - display-active request, sampled at slot start
//   bitmap_addr, attr_addr  - byte addresses (row = low MA_W, col = next MA_W)
//   d_in                    - VRAM read data
//   ma, ma_n_oe             - multiplexed DRAM address and its pad enable (low)
//   n_ras, n_cas            - DRAM strobes
//   bitmap_q, attr_q        - latched fetch data
//   data_valid              - one-cycle pulse when bitmap_q/attr_q update
//   contend                 - high throughout an active slot
module ula_vram_fetch #(
  parameter int unsigned MA_W = ula_vram_pkg::MA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              fetch_en,
  input  logic [2*MA_W-1:0] bitmap_addr,
  input  logic [2*MA_W-1:0] attr_addr,
  input  logic [7:0]        d_in,
  output logic [MA_W-1:0]   ma,
  output logic              ma_n_oe,
  output logic              n_ras,
  output logic              n_cas,
  output logic [7:0]        bitmap_q,
  output logic [7:0]        attr_q,
  output logic              data_valid,
  output logic              contend
);
  import ula_vram_pkg::*;

  logic [SC_W-1:0]   sc;
  logic [SC_W-1:0]   sc_next;
  logic              slot_start;
  logic              rfsh_inc;
  logic [MA_W-1:0]   rfsh;

  slot_mode_e        mode;
  slot_mode_e        mode_next;
  logic [2*MA_W-1:0] b_addr;
  logic [2*MA_W-1:0] a_addr;
  logic [2*MA_W-1:0] b_addr_next;
  logic [2*MA_W-1:0] a_addr_next;

  logic [MA_W-1:0]   ma_d;
  logic              ma_n_oe_d;
  logic              n_ras_d;
  logic              n_cas_d;
  logic              contend_d;
  logic              attr_phase;
  logic [MA_W-1:0]   row_sel;
  logic [MA_W-1:0]   col_sel;

  // Refresh row advances at the end of the RAS-only strobe of an idle slot.
  assign rfsh_inc = (mode == SLOT_IDLE) && (sc == CYC_LAT_B);

  ula_vram_slot_ctr #(.MA_W(MA_W)) u_slot_ctr (
    .clk          (clk),
    .n_reset      (n_reset),
    .rfsh_inc     (rfsh_inc),
    .sc           (sc),
    .sc_next_c    (sc_next),
    .slot_start_c (slot_start),
    .rfsh         (rfsh)
  );

  // Slot mode and addresses: captured at slot start, held for the slot.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode   <= SLOT_IDLE;
      b_addr <= '0;
      a_addr <= '0;
    end else begin
      mode   <= mode_next;
      b_addr <= b_addr_next;
      a_addr <= a_addr_next;
    end
  end

  always_comb begin
    mode_next   = mode;
    b_addr_next = b_addr;
    a_addr_next = a_addr;
    if (slot_start) begin
      mode_next   = fetch_en ? SLOT_ACTIVE : SLOT_IDLE;
      b_addr_next = bitmap_addr;
      a_addr_next = attr_addr;
    end
  end

  // Pin decode for the cycle about to start, so registered pins line up with sc.
  always_comb begin
    ma_d       = ma;
    ma_n_oe_d  = 1'b1;
    n_ras_d    = 1'b1;
    n_cas_d    = 1'b1;
    contend_d  = 1'b0;
    attr_phase = (sc_next >= CYC_ROW_A);
    row_sel    = attr_phase ? a_addr_next[MA_W-1:0] : b_addr_next[MA_W-1:0];
    col_sel    = attr_phase ? a_addr_next[2*MA_W-1:MA_W] : b_addr_next[2*MA_W-1:MA_W];
    if (mode_next == SLOT_ACTIVE) begin
      // Each half-slot: precharge, RAS on row, then two CAS cycles on column.
      ma_n_oe_d = 1'b0;
      contend_d = 1'b1;
      ma_d      = sc_next[1] ? col_sel : row_sel;
      n_ras_d   = (sc_next[1:0] == 2'd0);
      n_cas_d   = ~sc_next[1];
    end else if (!attr_phase) begin
      // RAS-only refresh in the first half; second half keeps ma and frees the pads.
      ma_n_oe_d = 1'b0;
      ma_d      = rfsh;
      n_ras_d   = (sc_next == CYC_ROW_B);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ma      <= '0;
      ma_n_oe <= 1'b1;
      n_ras   <= 1'b1;
      n_cas   <= 1'b1;
      contend <= 1'b0;
    end else begin
      ma      <= ma_d;
      ma_n_oe <= ma_n_oe_d;
      n_ras   <= n_ras_d;
      n_cas   <= n_cas_d;
      contend <= contend_d;
    end
  end

  // Data latches close on the last CAS cycle of each half of an active slot.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bitmap_q   <= '0;
      attr_q     <= '0;
      data_valid <= 1'b0;
    end else begin
      if ((mode == SLOT_ACTIVE) && (sc == CYC_LAT_B)) bitmap_q <= d_in;
      if ((mode == SLOT_ACTIVE) && (sc == CYC_LAT_A)) attr_q   <= d_in;
      data_valid <= (mode == SLOT_ACTIVE) && (sc == CYC_LAT_A);
    end
  end

endmodule

// File: tb/tb_ula_vram_fetch.sv
// Directed and randomized checks for the ULA VRAM fetch sequencer.
module tb_ula_vram_fetch;

  localparam int unsigned MA_W = 7;

  // Expected per-cycle pin values, bit k = slot cycle k.
  localparam logic [7:0] ACT_NRAS  = 8'h11;
  localparam logic [7:0] ACT_NCAS  = 8'h33;
  localparam logic [7:0] IDLE_NRAS = 8'hF1;
  localparam logic [7:0] IDLE_OE   = 8'hF0;
  localparam logic [6:0] ACT_MA [8] = '{7'h3C, 7'h3C, 7'h35, 7'h35, 7'h05, 7'h05, 7'h36, 7'h36};

  logic              clk;
  logic              n_reset;
  logic              fetch_en;
  logic [2*MA_W-1:0] bitmap_addr;
  logic [2*MA_W-1:0] attr_addr;
  logic [7:0]        d_in;
  logic [MA_W-1:0]   ma;
  logic              ma_n_oe;
  logic              n_ras;
  logic              n_cas;
  logic [7:0]        bitmap_q;
  logic [7:0]        attr_q;
  logic              data_valid;
  logic              contend;

  int unsigned n_checks;
  int unsigned n_fail;

  // Bench-side slot model.
  logic [2:0] bsc;
  logic       exp_active;
  logic [6:0] exp_rfsh;
  logic       exp_dv;

  ula_vram_fetch #(.MA_W(MA_W)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .fetch_en    (fetch_en),
    .bitmap_addr (bitmap_addr),
    .attr_addr   (attr_addr),
    .d_in        (d_in),
    .ma          (ma),
    .ma_n_oe     (ma_n_oe),
    .n_ras       (n_ras),
    .n_cas       (n_cas),
    .bitmap_q    (bitmap_q),
    .attr_q      (attr_q),
    .data_valid  (data_valid),
    .contend     (contend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    logic fe;
    fe = fetch_en;
    @(posedge clk);
    #1;
    exp_dv = (bsc == 3'd7) && exp_active;
    if (bsc == 3'd3 && !exp_active) exp_rfsh = exp_rfsh + 7'd1;
    if (bsc == 3'd7) exp_active = fe;
    bsc = bsc + 3'd1;
  endtask

  task automatic go_to(input logic [2:0] k);
    for (int i = 0; i < 8 && bsc != k; i++) step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    n_reset    = 1'b1;
    bsc        = 3'd0;
    exp_active = 1'b0;
    exp_rfsh   = 7'd0;
    exp_dv     = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({n_ras, n_cas, ma_n_oe} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 111", {n_ras, n_cas, ma_n_oe});
    end
    n_checks++;
    if (ma !== 7'h00) begin
      n_fail++;
      $display("FAIL reset_ma: got %h required 00", ma);
    end
    n_checks++;
    if ({bitmap_q, attr_q} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0000", {bitmap_q, attr_q});
    end
    n_checks++;
    if ({data_valid, contend} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00", {data_valid, contend});
    end
    release_reset();
  endtask

  // 130 refresh slots from reset: ma walks 0..127, 0, 1.
  task automatic test_idle();
    logic [6:0] row;
    fetch_en = 1'b0;
    for (int s = 0; s < 130; s++) begin
      row = 7'(s);
      for (int k = (s == 0) ? 1 : 0; k < 8; k++) begin
        step();
        n_checks++;
        if (ma !== row) begin
          n_fail++;
          $display("FAIL idle_ma slot %0d cyc %0d: got %h required %h", s, k, ma, row);
        end
        n_checks++;
        if (n_ras !== IDLE_NRAS[k] || n_cas !== 1'b1) begin
          n_fail++;
          $display("FAIL idle_strobes slot %0d cyc %0d: got ras %b cas %b required ras %b cas 1",
                   s, k, n_ras, n_cas, IDLE_NRAS[k]);
        end
        n_checks++;
        if (ma_n_oe !== IDLE_OE[k] || contend !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_oe slot %0d cyc %0d: got oe %b contend %b required oe %b contend 0",
                   s, k, ma_n_oe, contend, IDLE_OE[k]);
        end
      end
    end
  endtask

  task automatic test_active();
    go_to(3'd7);
    fetch_en    = 1'b1;
    bitmap_addr = 14'h1ABC;
    attr_addr   = 14'h1B05;
    d_in        = 8'h00;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if (ma !== ACT_MA[k]) begin
        n_fail++;
        $display("FAIL active_ma cyc %0d: got %h required %h", k, ma, ACT_MA[k]);
      end
      n_checks++;
      if (n_ras !== ACT_NRAS[k] || n_cas !== ACT_NCAS[k]) begin
        n_fail++;
        $display("FAIL active_strobes cyc %0d: got ras %b cas %b required ras %b cas %b",
                 k, n_ras, n_cas, ACT_NRAS[k], ACT_NCAS[k]);
      end
      n_checks++;
      if ({ma_n_oe, contend, data_valid} !== 3'b010) begin
        n_fail++;
        $display("FAIL active_flags cyc %0d: got %b required 010", k, {ma_n_oe, contend, data_valid});
      end
      if (k == 1) begin
        bitmap_addr = 14'h0000;
        attr_addr   = 14'h0000;
      end
      if (k == 3) d_in = 8'hA5;
      if (k == 5) begin
        n_checks++;
        if (bitmap_q !== 8'hA5) begin
          n_fail++;
          $display("FAIL active_bitmap_early: got %h required a5", bitmap_q);
        end
      end
      if (k == 7) begin
        d_in     = 8'h3C;
        fetch_en = 1'b0;
      end
    end
    step();
    n_checks++;
    if ({data_valid, contend} !== 2'b10) begin
      n_fail++;
      $display("FAIL active_dv: got dv %b contend %b required dv 1 contend 0", data_valid, contend);
    end
    n_checks++;
    if ({bitmap_q, attr_q} !== 16'hA53C) begin
      n_fail++;
      $display("FAIL active_data: got %h required a53c", {bitmap_q, attr_q});
    end
    n_checks++;
    if (ma !== exp_rfsh) begin
      n_fail++;
      $display("FAIL active_next_rfsh: got %h required %h", ma, exp_rfsh);
    end
    step();
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL active_dv_width: got %b required 0", data_valid);
    end
  endtask

  task automatic test_mid_slot();
    go_to(3'd7);
    fetch_en    = 1'b1;
    bitmap_addr = 14'h0123;
    attr_addr   = 14'h0F81;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 2) begin
        fetch_en    = 1'b0;
        bitmap_addr = 14'h3FFF;
        attr_addr   = 14'h3FFF;
      end
      n_checks++;
      if (contend !== 1'b1 || ma_n_oe !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_contend cyc %0d: got contend %b oe %b required 1 0", k, contend, ma_n_oe);
      end
      if (k == 4) begin
        n_checks++;
        if (ma !== 7'h01) begin
          n_fail++;
          $display("FAIL mid_row_a: got %h required 01", ma);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (ma !== 7'h1F || n_cas !== 1'b0) begin
          n_fail++;
          $display("FAIL mid_col_a: got ma %h cas %b required 1f 0", ma, n_cas);
        end
      end
    end
    step();
    n_checks++;
    if ({data_valid, contend} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_next_flags: got %b required 10", {data_valid, contend});
    end
    step();
    n_checks++;
    if ({n_ras, n_cas, ma_n_oe} !== 3'b010 || ma !== exp_rfsh) begin
      n_fail++;
      $display("FAIL mid_next_refresh: got strobes %b ma %h required 010 %h",
               {n_ras, n_cas, ma_n_oe}, ma, exp_rfsh);
    end
  endtask

  task automatic test_back_to_back();
    go_to(3'd7);
    fetch_en    = 1'b1;
    bitmap_addr = 14'h0000;
    attr_addr   = 14'h3FFF;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 3) d_in = 8'h11;
      if (k == 6) begin
        n_checks++;
        if (ma !== 7'h7F) begin
          n_fail++;
          $display("FAIL b2b_col_a: got %h required 7f", ma);
        end
      end
      if (k == 7) begin
        d_in        = 8'h22;
        bitmap_addr = 14'h2081;
      end
    end
    step();
    n_checks++;
    if ({n_ras, n_cas, contend, data_valid} !== 4'b1111) begin
      n_fail++;
      $display("FAIL b2b_precharge: got %b required 1111", {n_ras, n_cas, contend, data_valid});
    end
    n_checks++;
    if (ma !== 7'h01 || {bitmap_q, attr_q} !== 16'h1122) begin
      n_fail++;
      $display("FAIL b2b_cyc0: got ma %h data %h required 01 1122", ma, {bitmap_q, attr_q});
    end
    for (int k = 1; k < 8; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (data_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_dv_width: got %b required 0", data_valid);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (ma !== 7'h41) begin
          n_fail++;
          $display("FAIL b2b_col_b: got %h required 41", ma);
        end
      end
      if (k == 3) d_in = 8'h33;
      if (k == 7) begin
        d_in     = 8'h44;
        fetch_en = 1'b0;
      end
    end
    step();
    n_checks++;
    if ({bitmap_q, attr_q} !== 16'h3344 || data_valid !== 1'b1 || contend !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got data %h dv %b contend %b required 3344 1 0",
               {bitmap_q, attr_q}, data_valid, contend);
    end
  endtask

  task automatic test_reset_mid();
    go_to(3'd7);
    fetch_en    = 1'b1;
    bitmap_addr = 14'h1ABC;
    attr_addr   = 14'h1B05;
    d_in        = 8'h77;
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if (bitmap_q !== 8'h77) begin
      n_fail++;
      $display("FAIL rstmid_pre_bitmap: got %h required 77", bitmap_q);
    end
    #2;
    n_reset = 1'b0;
    #1;
    n_checks++;
    if ({n_ras, n_cas, ma_n_oe, contend} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b required 1110", {n_ras, n_cas, ma_n_oe, contend});
    end
    n_checks++;
    if ({bitmap_q, attr_q} !== 16'h0000 || ma !== 7'h00) begin
      n_fail++;
      $display("FAIL rstmid_clear: got data %h ma %h required 0000 00", {bitmap_q, attr_q}, ma);
    end
    release_reset();
    for (int k = 1; k < 8; k++) begin
      step();
      n_checks++;
      if (ma !== 7'h00 || n_ras !== IDLE_NRAS[k] || n_cas !== 1'b1 ||
          ma_n_oe !== IDLE_OE[k] || contend !== 1'b0 || attr_q !== 8'h00) begin
        n_fail++;
        $display("FAIL rstmid_refresh cyc %0d: got ma %h ras %b cas %b oe %b contend %b attr %h",
                 k, ma, n_ras, n_cas, ma_n_oe, contend, attr_q);
      end
    end
    step();
    n_checks++;
    if (contend !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_next_active: got contend %b dv %b required 1 0", contend, data_valid);
    end
  endtask

  task automatic test_random();
    logic prev_dv;
    prev_dv = data_valid;
    for (int i = 0; i < 10000; i++) begin
      fetch_en    = 1'($urandom_range(0, 1));
      bitmap_addr = 14'($urandom);
      attr_addr   = 14'($urandom);
      d_in        = 8'($urandom);
      step();
      n_checks++;
      if (n_cas === 1'b0 && n_ras !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_cas_without_ras iter %0d: got ras %b cas %b", i, n_ras, n_cas);
      end
      if (bsc == 3'd0) begin
        n_checks++;
        if (n_ras !== 1'b1 || n_cas !== 1'b1) begin
          n_fail++;
          $display("FAIL rand_precharge iter %0d: got ras %b cas %b required 1 1", i, n_ras, n_cas);
        end
      end
      n_checks++;
      if (prev_dv === 1'b1 && data_valid === 1'b1) begin
        n_fail++;
        $display("FAIL rand_dv_double iter %0d: got dv 1 twice", i);
      end
      n_checks++;
      if (data_valid !== exp_dv || contend !== exp_active) begin
        n_fail++;
        $display("FAIL rand_flags iter %0d: got dv %b contend %b required %b %b",
                 i, data_valid, contend, exp_dv, exp_active);
      end
      prev_dv = data_valid;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_reset     = 1'b1;
    fetch_en    = 1'b0;
    bitmap_addr = '0;
    attr_addr   = '0;
    d_in        = '0;
    bsc         = 3'd0;
    exp_active  = 1'b0;
    exp_rfsh    = 7'd0;
    exp_dv      = 1'b0;
    test_reset();
    test_idle();
    test_active();
    test_mid_slot();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_vram_fetch.md
ULA_VRAM_FETCH -- requirements
Module: ula_vram_fetch

Interface
REQ-001 Parameter MA_W, default 7: DRAM multiplexed address width; the row uses the low MA_W bits of an address and the column uses the next MA_W bits.
REQ-002 clk  input  1  pixel clock (7 MHz, from osc pad path); single clock domain.
REQ-003 n_reset  input  1  reset; asynchronous, active-low.
REQ-004 fetch_en  input  1  display-active request, sampled only at slot start.
REQ-005 bitmap_addr  input  2*MA_W  bitmap byte address from the video counter.
REQ-006 attr_addr  input  2*MA_W  attribute byte address from the video counter.
REQ-007 d_in  input  8  VRAM read data, from the data input pads.
REQ-008 ma  output  MA_W  multiplexed DRAM address, to the address output pads.
REQ-009 ma_n_oe  output  1  0 = sequencer drives ma; 1 = pads released to the CPU.
REQ-010 n_ras  output  1  DRAM RAS, to the RAS pad.
REQ-011 n_cas  output  1  DRAM CAS, to the CAS pad.
REQ-012 bitmap_q  output  8  latched bitmap byte.
REQ-013 attr_q  output  8  latched attribute byte.
REQ-014 data_valid  output  1  one-cycle pulse: bitmap_q/attr_q are updated.
REQ-015 contend  output  1  high during an active fetch slot; used for CPU clock contention.

Function
REQ-016 A 3-bit slot counter sc SHALL increment on every clk edge and wrap 7->0; an edge on which sc goes 7->0 is a slot-start edge.
REQ-017 At each slot-start edge the block SHALL capture fetch_en, bitmap_addr and attr_addr; the captured values govern the whole slot, and changes to these inputs mid-slot SHALL be ignored.
REQ-018 All outputs SHALL be registered; a value stated for "cycle k" is present throughout the clock period in which sc==k.
REQ-019 Active slot (captured fetch_en=1), bitmap phase: cycle 0 ma=row_b, n_ras=1, n_cas=1; cycle 1 ma=row_b, n_ras=0; cycles 2-3 ma=col_b, n_ras=0, n_cas=0.
REQ-020 Active slot, attribute phase: cycle 4 ma=row_a, n_ras=1, n_cas=1; cycle 5 ma=row_a, n_ras=0; cycles 6-7 ma=col_a, n_ras=0, n_cas=0.
REQ-021 Active slot latching: bitmap_q SHALL take d_in on the edge ending cycle 3, and attr_q SHALL take d_in on the edge ending cycle 7.
REQ-022 Active slot flags: ma_n_oe=0 and contend=1 for all 8 cycles; data_valid=1 only during cycle 0 of the following slot.
REQ-023 Idle slot (captured fetch_en=0) SHALL perform a RAS-only refresh: ma=rfsh in cycles 0-3; n_ras=0 in cycles 1-3; n_cas=1 throughout; ma_n_oe=0 in cycles 0-3 and 1 in cycles 4-7; contend=0.
REQ-024 rfsh is an MA_W-bit counter; it SHALL increment on the edge ending cycle 3 of each idle slot and wrap from all-ones to 0.
REQ-025 In cycles 4-7 of an idle slot, n_ras=n_cas=1 and ma SHALL hold its cycle-3 value.
REQ-026 bitmap_q and attr_q SHALL hold their values through idle slots.
REQ-027 n_cas=0 SHALL never occur while n_ras=1.
REQ-028 Back-to-back active slots SHALL pass through cycle 0 with n_ras=1 and n_cas=1 (precharge).

Reset
REQ-029 While n_reset=0: sc=0, rfsh=0, n_ras=1, n_cas=1, ma_n_oe=1, ma=0, bitmap_q=0, attr_q=0, data_valid=0, contend=0, and the captured fetch_en=0.
REQ-030 Reset asserted mid-slot SHALL abort the access immediately (asynchronously); no partial latch of d_in occurs.
REQ-031 After reset release, the first edge SHALL be a normal increment from sc=0; that first slot behaves as an idle slot with captured fetch_en=0, i.e. a refresh slot.

Structure
REQ-032 Shared package ula_vram_pkg SHALL hold: the slot cycle constants (CYC_ROW_B=0, CYC_LAT_B=3, CYC_ROW_A=4, CYC_LAT_A=7), the MA_W default, and the slot-mode enum {SLOT_IDLE, SLOT_ACTIVE}.
REQ-033 The slot counter plus refresh counter SHALL be one sub-module, ula_vram_slot_ctr; decode and latches stay in ula_vram_fetch.

Verification
REQ-034 Active slot: fetch_en=1, bitmap_addr=0x1ABC, attr_addr=0x1B05, d_in=0xA5 in cycle 3 and 0x3C in cycle 7 -> ma = 0x3C, 0x3C, 0x35, 0x35, 0x05, 0x05, 0x36, 0x36; bitmap_q=0xA5, attr_q=0x3C; data_valid pulses in next cycle 0.
REQ-035 Idle slots: fetch_en=0 for 130 slots from reset -> rfsh sequence 0..127, 0, 1 on ma; n_cas never 0; contend=0.
REQ-036 Mid-slot change: fetch_en toggles 1->0 at cycle 2 of an active slot -> the slot completes as active; the next slot refreshes.
REQ-037 Reset at cycle 5 of an active slot -> n_ras=n_cas=1 and ma_n_oe=1 immediately; attr_q=0; the first slot after release is a refresh slot with ma=0.
REQ-038 Continuous assertions over 10k random cycles: no n_cas=0 with n_ras=1; precharge at every cycle 0; data_valid never high for 2 consecutive cycles.
